// File: rtl/back_ground_draw_regions_pkg.sv
// Shared types and colour constants for the background region painter.
package bg_draw_pkg;

    typedef enum logic [1:0] {
        ModeSolid  = 2'd0,
        ModeBlink  = 2'd1,
        ModeScroll = 2'd2,
        ModeRsvd   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        FieldX0    = 3'd0,
        FieldX1    = 3'd1,
        FieldY0    = 3'd2,
        FieldY1    = 3'd3,
        FieldColor = 3'd4,
        FieldCtrl  = 3'd5
    } field_e;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] x1;
        logic [10:0] y0;
        logic [10:0] y1;
        logic [7:0]  color;
        logic        en;
        mode_e       mode;
    } rect_t;

    localparam logic [7:0] BORDER_COLOR  = 8'hFC;
    localparam logic [7:0] BRACKET_COLOR = 8'hFF;
    localparam logic [7:0] DEFAULT_COLOR = 8'h58;
    localparam logic [7:0] RESET_COLOR   = 8'hFF;

    localparam rect_t RECT_CLEAR = '{
        x0: 11'd0, x1: 11'd0, y0: 11'd0, y1: 11'd0,
        color: 8'd0, en: 1'b0, mode: ModeSolid
    };

endpackage

// File: rtl/back_ground_draw_regions_if.sv
// Region configuration write bus: valid/ready strobe with index, field and data.
interface back_ground_draw_regions_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_idx;
    logic [2:0]  cfg_field;
    logic [10:0] cfg_wdata;

    modport master (
        output cfg_valid, cfg_idx, cfg_field, cfg_wdata,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_field, cfg_wdata,
        output cfg_ready
    );
endinterface

// File: rtl/back_ground_draw_regions_rect_hit.sv
// One region: bounds compare plus mode visibility, registered hit flag and colour.
module bg_rect_hit
    import bg_draw_pkg::*;
#(
    parameter int unsigned BLINK_BIT    = 4,
    parameter int unsigned STRIPE_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  rect_t       rect,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [7:0]  frame_cnt,
    output logic        hit,
    output logic [7:0]  color
);

    logic        in_x;
    logic        in_y;
    logic        visible;
    logic [10:0] scroll_pos;
    logic        hit_d;

    // Empty regions (x1<=x0 or y1<=y0) fall out of these compares naturally.
    assign in_x       = (pixel_x >= rect.x0) && (pixel_x < rect.x1);
    assign in_y       = (pixel_y >= rect.y0) && (pixel_y < rect.y1);
    assign scroll_pos = pixel_x + {3'b000, frame_cnt};

    always_comb begin
        visible = 1'b0;
        case (rect.mode)
            ModeSolid:  visible = 1'b1;
            ModeBlink:  visible = ~frame_cnt[BLINK_BIT];
            ModeScroll: visible = ~scroll_pos[STRIPE_SHIFT];
            default:    visible = 1'b0;
        endcase
        hit_d = rect.en && visible && in_x && in_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit   <= 1'b0;
            color <= 8'h00;
        end else begin
            hit   <= hit_d;
            color <= rect.color;
        end
    end

endmodule

// File: rtl/back_ground_draw_regions.sv
// Background painter: border, brackets and programmable regions, 2-cycle pixel latency.
// Define BG_GRADIENT_EN to replace the flat default colour with a vertical gradient.
module back_ground_draw_regions
    import bg_draw_pkg::*;
#(
    parameter int unsigned X_SIZE         = 640,
    parameter int unsigned Y_SIZE         = 480,
    parameter int unsigned BRACKET_OFFSET = 10,
    parameter int unsigned NUM_RECTS      = 4,
    parameter int unsigned BLINK_BIT      = 4,
    parameter int unsigned STRIPE_SHIFT   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [10:0]                 pixelX,
    input  logic [10:0]                 pixelY,
    input  logic                        startOfFrame,
    back_ground_draw_regions_if.slave   cfg,
    output logic [7:0]                  BG_RGB
);

    localparam logic [10:0] XMax   = 11'(X_SIZE - 1);
    localparam logic [10:0] YMax   = 11'(Y_SIZE - 1);
    localparam logic [10:0] BrLo   = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BrXHi  = 11'(X_SIZE - 1 - BRACKET_OFFSET);
    localparam logic [10:0] BrYHi  = 11'(Y_SIZE - 1 - BRACKET_OFFSET);

    rect_t shadow_q [NUM_RECTS];
    rect_t shadow_d [NUM_RECTS];
    rect_t active_q [NUM_RECTS];
    logic [7:0] frame_cnt_q;
    logic       cfg_wr;

    assign cfg.cfg_ready = ~reset;
    assign cfg_wr        = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < int'(NUM_RECTS); i++) begin
            if (cfg_wr && (cfg.cfg_idx == 3'(i))) begin
                case (cfg.cfg_field)
                    FieldX0:    shadow_d[i].x0    = cfg.cfg_wdata;
                    FieldX1:    shadow_d[i].x1    = cfg.cfg_wdata;
                    FieldY0:    shadow_d[i].y0    = cfg.cfg_wdata;
                    FieldY1:    shadow_d[i].y1    = cfg.cfg_wdata;
                    FieldColor: shadow_d[i].color = cfg.cfg_wdata[7:0];
                    FieldCtrl: begin
                        shadow_d[i].en   = cfg.cfg_wdata[0];
                        shadow_d[i].mode = mode_e'(cfg.cfg_wdata[2:1]);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Commit takes shadow_d so a write in the startOfFrame cycle lands in this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '{default: RECT_CLEAR};
            active_q    <= '{default: RECT_CLEAR};
            frame_cnt_q <= 8'd0;
        end else begin
            shadow_q <= shadow_d;
            if (startOfFrame) begin
                active_q    <= shadow_d;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // Stage 1: per-region hits plus frame-geometry flags.
    logic [NUM_RECTS-1:0] hit_q;
    logic [7:0]           color_q [NUM_RECTS];
    logic                 border_q;
    logic                 bracket_q;
    logic [7:0]           base_q;
    logic [7:0]           base_d;

    for (genvar g = 0; g < int'(NUM_RECTS); g++) begin : g_rect
        bg_rect_hit #(
            .BLINK_BIT    (BLINK_BIT),
            .STRIPE_SHIFT (STRIPE_SHIFT)
        ) u_hit (
            .clk       (clk),
            .reset     (reset),
            .rect      (active_q[g]),
            .pixel_x   (pixelX),
            .pixel_y   (pixelY),
            .frame_cnt (frame_cnt_q),
            .hit       (hit_q[g]),
            .color     (color_q[g])
        );
    end

`ifdef BG_GRADIENT_EN
    assign base_d = {3'b010, pixelY[8:6], pixelY[8:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= 8'h00;
        end else begin
            base_q <= base_d;
        end
    end
`else
    assign base_d = DEFAULT_COLOR;
    assign base_q = base_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            border_q  <= 1'b0;
            bracket_q <= 1'b0;
        end else begin
            border_q  <= (pixelX == 11'd0) || (pixelX == XMax) ||
                         (pixelY == 11'd0) || (pixelY == YMax);
            bracket_q <= (pixelX == BrLo) || (pixelY == BrLo) ||
                         (pixelX == BrXHi) || (pixelY == BrYHi);
        end
    end

    // Stage 2: later assignments win, so the loop order gives highest index priority.
    logic [7:0] rgb_d;
    logic [7:0] rgb_q;

    always_comb begin
        rgb_d = base_q;
        if (border_q) begin
            rgb_d = BORDER_COLOR;
        end
        if (bracket_q) begin
            rgb_d = BRACKET_COLOR;
        end
        for (int i = 0; i < int'(NUM_RECTS); i++) begin
            if (hit_q[i]) begin
                rgb_d = color_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= RESET_COLOR;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign BG_RGB = rgb_q;

endmodule

// File: tb/tb_back_ground_draw_regions.sv
// Randomised bench for back_ground_draw_regions against a behavioural frame model.
module tb_back_ground_draw_regions;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  BG_RGB;

    back_ground_draw_regions_if cfg_if ();

    back_ground_draw_regions #(
        .X_SIZE         (640),
        .Y_SIZE         (480),
        .BRACKET_OFFSET (10),
        .NUM_RECTS      (NR),
        .BLINK_BIT      (4),
        .STRIPE_SHIFT   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .cfg          (cfg_if.slave),
        .BG_RGB       (BG_RGB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string cur_tag = "reset";

    // Model state: fields indexed 0=x0 1=x1 2=y0 3=y1 4=color 5=ctrl, raw write data.
    int sh  [NR][6];
    int act [NR][6];
    int fc;
    int exp1 = -1;
    int exp2 = -1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int expect_rgb(input int x, input int y);
        for (int i = NR - 1; i >= 0; i--) begin
            int en;
            int mode;
            bit vis;
            en   = act[i][5] & 1;
            mode = (act[i][5] >> 1) & 3;
            case (mode)
                0:       vis = 1'b1;
                1:       vis = ((fc / 16) % 2) == 0;
                2:       vis = ((((x + fc) % 2048) / 8) % 2) == 0;
                default: vis = 1'b0;
            endcase
            if (en == 1 && vis && x >= act[i][0] && x < act[i][1] &&
                y >= act[i][2] && y < act[i][3]) begin
                return act[i][4] % 256;
            end
        end
        if (x == 10 || y == 10 || x == 629 || y == 469) return 'hFF;
        if (x == 0 || y == 0 || x == 639 || y == 479) return 'hFC;
        return 'h58;
    endfunction

    task automatic cycle(input bit rst, input int x, input int y, input bit sof,
                         input bit cv, input int idx, input int fld, input int wd);
        @(negedge clk);
        if (exp2 >= 0) check_eq(cur_tag, BG_RGB, 8'(exp2));
        reset               = rst;
        pixelX              = 11'(x);
        pixelY              = 11'(y);
        startOfFrame        = sof;
        cfg_if.cfg_valid    = cv;
        cfg_if.cfg_idx      = 3'(idx);
        cfg_if.cfg_field    = 3'(fld);
        cfg_if.cfg_wdata    = 11'(wd);
        #1;
        check_eq("cfg_ready", {7'b0, cfg_if.cfg_ready}, {7'b0, ~rst});
        if (rst) begin
            exp2 = 'hFF;
            exp1 = 'h58;
            for (int i = 0; i < NR; i++)
                for (int f = 0; f < 6; f++) begin
                    sh[i][f]  = 0;
                    act[i][f] = 0;
                end
            fc = 0;
        end else begin
            exp2 = exp1;
            exp1 = expect_rgb(x, y);
            if (cv && idx < NR && fld <= 5) sh[idx][fld] = wd;
            if (sof) begin
                act = sh;
                fc  = (fc + 1) % 256;
            end
        end
    endtask

    task automatic pix(input int x, input int y);
        cycle(1'b0, x, y, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wr(input int idx, input int fld, input int wd);
        cycle(1'b0, 150, 55, 1'b0, 1'b1, idx, fld, wd);
    endtask

    task automatic sof_pulse();
        cycle(1'b0, 300, 300, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic region(input int idx, input int x0, input int x1, input int y0,
                          input int y1, input int col, input int ctrl);
        wr(idx, 0, x0);
        wr(idx, 1, x1);
        wr(idx, 2, y0);
        wr(idx, 3, y1);
        wr(idx, 4, col);
        wr(idx, 5, ctrl);
    endtask

    initial begin
        fc = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, 0);

        cur_tag = "frame";
        pix(0, 0);
        pix(10, 100);
        pix(300, 300);
        pix(639, 479);
        pix(629, 200);
        pix(200, 469);

        cur_tag = "region_commit";
        region(0, 100, 200, 50, 60, 'h1C, 1);
        pix(150, 55);
        pix(150, 55);
        sof_pulse();
        pix(150, 55);
        pix(200, 55);
        pix(100, 50);
        pix(199, 59);
        pix(150, 60);

        cur_tag = "priority";
        region(3, 110, 130, 50, 60, 'hE0, 1);
        sof_pulse();
        pix(120, 55);
        pix(105, 55);
        wr(3, 5, 0);
        sof_pulse();
        pix(120, 55);

        cur_tag = "blink_wrap";
        wr(0, 5, 3);
        for (int f = 0; f < 300; f++) begin
            sof_pulse();
            pix(150, 55);
        end

        cur_tag = "scroll";
        wr(0, 5, 5);
        for (int f = 0; f < 6; f++) begin
            sof_pulse();
            for (int x = 96; x < 124; x++) pix(x, 55);
        end

        cur_tag = "bad_idx";
        wr(5, 4, 'h03);
        wr(0, 7, 'h03);
        sof_pulse();
        pix(150, 55);

        cur_tag = "sof_bypass";
        wr(0, 5, 1);
        cycle(1'b0, 150, 55, 1'b1, 1'b1, 0, 4, 'h55);
        pix(150, 55);
        pix(150, 55);

        cur_tag = "mid_reset";
        cycle(1'b1, 150, 55, 1'b0, 1'b0, 0, 0, 0);
        pix(150, 55);
        pix(150, 55);
        sof_pulse();
        pix(150, 55);

        cur_tag = "random";
        for (int n = 0; n < 4000; n++) begin
            bit rst;
            bit sof;
            bit cv;
            int x;
            int y;
            int fld;
            int wd;
            rst = ($urandom_range(0, 499) == 0);
            sof = ($urandom_range(0, 39) == 0);
            cv  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       x = $urandom_range(0, 2047);
                1:       x = ($urandom_range(0, 1) == 1) ? 10 : 629;
                2:       x = ($urandom_range(0, 1) == 1) ? 0 : 639;
                default: x = $urandom_range(0, 700);
            endcase
            y   = ($urandom_range(0, 9) == 0) ? 10 * $urandom_range(0, 48) - 1 + $urandom_range(0, 2)
                                               : $urandom_range(0, 520);
            if (y < 0) y = 0;
            fld = $urandom_range(0, 7);
            case (fld)
                4:       wd = $urandom_range(0, 2047);
                5:       wd = $urandom_range(0, 7);
                default: wd = $urandom_range(0, 700);
            endcase
            cycle(rst, x, y, sof, cv, $urandom_range(0, 7), fld, wd);
        end
        pix(0, 0);
        pix(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
